pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 16-bit pipeline around the opcode decoder: detects load-use hazards,
//  applies branch flushes resolved in EX, holds the pipeline while a multi-cycle MUL
//  occupies EX, and freezes all stages on an external hold from the UART/memory side.
//  Sits between the ID stage (decoded opcode, register indices) and the pipeline
//  register enables. Also keeps a saturating stall-cycle counter for debug readout.
// PARAMETERS
//  RA_W     4   register-index width
//  MUL_LAT  3   cycles a MUL (CAL_mul 4'b0100 / IMM_mul 4'b1000) occupies EX; >=1
//  CNT_W    16  width of stall-cycle counter
// PORTS
//  i_clk             in   1      clock, all state on rising edge
//  i_reset           in   1      synchronous, active-high reset
//  i_id_valid        in   1      ID stage holds a real instruction
//  i_id_opcode       in   4      opcode of ID instruction
//  i_id_rs           in   RA_W   source reg A of ID instruction
//  i_id_rt           in   RA_W   source reg B of ID instruction
//  i_id_uses_rt      in   1      ID instruction reads rt (0 for immediate forms)
//  i_ex_memtoreg     in   1      EX instruction is a load (LDA)
//  i_ex_rd           in   RA_W   destination reg of EX instruction
//  i_ex_branch_taken in   1      BAF branch resolved taken in EX this cycle
//  i_ext_hold        in   1      external freeze request (UART/memory busy)
//  o_pc_en           out  1      PC update enable
//  o_ifid_en         out  1      IF/ID register enable
//  o_ifid_flush      out  1      clear IF/ID to NOP
//  o_idex_en         out  1      ID/EX register enable
//  o_idex_bubble     out  1      load NOP into ID/EX
//  o_exmem_bubble    out  1      load NOP into EX/MEM
//  o_mul_busy        out  1      state == MUL_WAIT
//  o_stall_cnt       out  CNT_W  saturating count of cycles with o_pc_en==0
// BEHAVIOUR
//  - Control outputs are combinational from state+inputs; state, mul counter, and
//    stall counter are registered. Reset: state=RUN, mul_cnt=0, o_stall_cnt=0; outputs
//    then equal RUN with no event: all enables 1, flush/bubbles 0, o_mul_busy 0.
//  - States: RUN (2'b00), MUL_WAIT (2'b01). mul_cnt is $clog2(MUL_LAT)+1 bits wide.
//  - Event priority each cycle: i_ext_hold > branch > load-use > MUL issue.
//  - ext_hold (any state): all enables 0, no flush/bubble; state and mul_cnt frozen.
//  - RUN, branch taken: o_ifid_flush=1, o_idex_bubble=1, PC loads target (o_pc_en=1).
//    The ID instruction is squashed: no load-use stall, no MUL issue.
//  - RUN, load-use: i_id_valid & i_ex_memtoreg & (i_ex_rd==i_id_rs |
//    (i_id_uses_rt & i_ex_rd==i_id_rt)) -> o_pc_en=0, o_ifid_en=0, o_idex_bubble=1
//    for exactly 1 cycle. Register 0 is not special.
//  - RUN, MUL in ID with no higher event: issues normally. If MUL_LAT>1, next state
//    is MUL_WAIT with mul_cnt=MUL_LAT-1. If MUL_LAT==1, state stays RUN.
//  - MUL_WAIT: o_pc_en=o_ifid_en=o_idex_en=0, o_exmem_bubble=1, mul_cnt decrements.
//    At mul_cnt==1 the decrement returns to RUN, giving MUL_LAT-1 freeze cycles.
//    Branch and load-use inputs are ignored here, because EX holds the MUL.
//  - Back-to-back MULs: the second is seen in ID after release and issues normally.
//  - o_stall_cnt increments on every cycle with o_pc_en==0 and saturates at all-ones.
//  - Reset mid-MUL_WAIT: returns to RUN next edge and clears the counters.
// STRUCTURE
//  - Shared include cpu_defs.vh: opcode localparams (LDA_imm..BAF_regsub), state
//    encodings ST_RUN/ST_MUL_WAIT.
//  - One sub-module, hazard_detect (combinational load-use comparator, RA_W param).
//    FSM, mul counter and stall counter stay in this module.
// TESTING
//  - Reset: assert i_reset 2 cycles -> enables 1, flush/bubbles 0, o_stall_cnt 0.
//  - Load-use: EX LDA rd=3, ID CAL_add rs=3 -> 1 cycle pc_en=0, idex_bubble=1.
//    The same case with rt=3 and uses_rt=0 gives no stall.
//  - MUL, MUL_LAT=3: IMM_mul in ID -> 2 cycles MUL_WAIT (exmem_bubble=1), then RUN,
//    with o_stall_cnt +2.
//  - Branch and load-use in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1.
//    No stall is recorded.
//  - ext_hold for 4 cycles mid-MUL_WAIT -> mul_cnt frozen, MUL_WAIT resumes with its
//    remaining count. o_stall_cnt +4 plus the freeze cycles.
//  - Reset asserted during MUL_WAIT -> RUN and o_stall_cnt=0 next cycle.
//    Saturation: preload toward 16'hFFFF, hold stall -> counter stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the opcodes the controller has to recognise.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MUL_WAIT = 2'b01
    } state_e;

    localparam logic [3:0] OP_CAL_MUL = 4'b0100;
    localparam logic [3:0] OP_IMM_MUL = 4'b1000;

    function automatic logic isMul(input logic [3:0] opcode);
        return (opcode == OP_CAL_MUL) || (opcode == OP_IMM_MUL);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the ID stage / pipeline registers and the hazard controller.
// The master side is the pipeline, the slave side is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) ();

    logic             i_id_valid;
    logic [3:0]       i_id_opcode;
    logic [RA_W-1:0]  i_id_rs;
    logic [RA_W-1:0]  i_id_rt;
    logic             i_id_uses_rt;
    logic             i_ex_memtoreg;
    logic [RA_W-1:0]  i_ex_rd;
    logic             i_ex_branch_taken;
    logic             i_ext_hold;

    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_en;
    logic             o_idex_bubble;
    logic             o_exmem_bubble;
    logic             o_mul_busy;
    logic [CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_id_valid, i_id_opcode, i_id_rs, i_id_rt, i_id_uses_rt,
               i_ex_memtoreg, i_ex_rd, i_ex_branch_taken, i_ext_hold,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_bubble,
               o_exmem_bubble, o_mul_busy, o_stall_cnt
    );

    modport slave (
        input  i_id_valid, i_id_opcode, i_id_rs, i_id_rt, i_id_uses_rt,
               i_ex_memtoreg, i_ex_rd, i_ex_branch_taken, i_ext_hold,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_bubble,
               o_exmem_bubble, o_mul_busy, o_stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. Register 0 gets no special treatment.
module pipeline_hazard_ctrl_hazard_detect #(
    parameter int RA_W = 4
) (
    input  logic            idValid_i,
    input  logic [RA_W-1:0] idRs_i,
    input  logic [RA_W-1:0] idRt_i,
    input  logic            idUsesRt_i,
    input  logic            exMemToReg_i,
    input  logic [RA_W-1:0] exRd_i,
    output logic            loadUse_o
);

    assign loadUse_o = idValid_i & exMemToReg_i &
                       ((exRd_i == idRs_i) | (idUsesRt_i & (exRd_i == idRt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: external hold, branch flush, load-use stall and MUL
// occupancy of EX, plus a saturating count of cycles the PC was held.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RA_W    = 4,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int MUL_CNT_W = $clog2(MUL_LAT) + 1;
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_START = MUL_CNT_W'(MUL_LAT - 1);

    state_e                 state_q, state_d;
    logic [MUL_CNT_W-1:0]   mulCnt_q, mulCnt_d;
    logic [CNT_W-1:0]       stallCnt_q;
    logic                   loadUse;
    logic                   pcEn, ifidEn, ifidFlush, idexEn, idexBubble, exmemBubble;

    pipeline_hazard_ctrl_hazard_detect #(.RA_W(RA_W)) u_hazardDetect (
        .idValid_i    (bus.i_id_valid),
        .idRs_i       (bus.i_id_rs),
        .idRt_i       (bus.i_id_rt),
        .idUsesRt_i   (bus.i_id_uses_rt),
        .exMemToReg_i (bus.i_ex_memtoreg),
        .exRd_i       (bus.i_ex_rd),
        .loadUse_o    (loadUse)
    );

    // Events are resolved in priority order: hold, then the MUL occupying EX,
    // then branch, load-use and finally a new MUL issue.
    always_comb begin
        state_d     = state_q;
        mulCnt_d    = mulCnt_q;
        pcEn        = 1'b1;
        ifidEn      = 1'b1;
        ifidFlush   = 1'b0;
        idexEn      = 1'b1;
        idexBubble  = 1'b0;
        exmemBubble = 1'b0;
        if (bus.i_ext_hold) begin
            pcEn   = 1'b0;
            ifidEn = 1'b0;
            idexEn = 1'b0;
        end else begin
            case (state_q)
                ST_MUL_WAIT: begin
                    pcEn        = 1'b0;
                    ifidEn      = 1'b0;
                    idexEn      = 1'b0;
                    exmemBubble = 1'b1;
                    mulCnt_d    = mulCnt_q - MUL_CNT_W'(1);
                    if (mulCnt_q == MUL_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (bus.i_ex_branch_taken) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (loadUse) begin
                        pcEn       = 1'b0;
                        ifidEn     = 1'b0;
                        idexBubble = 1'b1;
                    end else if (bus.i_id_valid && isMul(bus.i_id_opcode) && (MUL_LAT > 1)) begin
                        state_d  = ST_MUL_WAIT;
                        mulCnt_d = MUL_CNT_START;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_RUN;
            mulCnt_q   <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mulCnt_q <= mulCnt_d;
            if (!pcEn && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.o_pc_en        = pcEn;
    assign bus.o_ifid_en      = ifidEn;
    assign bus.o_ifid_flush   = ifidFlush;
    assign bus.o_idex_en      = idexEn;
    assign bus.o_idex_bubble  = idexBubble;
    assign bus.o_exmem_bubble = exmemBubble;
    assign bus.o_mul_busy     = (state_q == ST_MUL_WAIT);
    assign bus.o_stall_cnt    = stallCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle-level reference model
// predicts each cycle's outputs, a monitor compares them on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int RA_W    = 4;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            reset;
        logic            valid;
        logic [3:0]      opcode;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            usesRt;
        logic            memToReg;
        logic [RA_W-1:0] rd;
        logic            branch;
        logic            hold;
    } stim_t;

    typedef struct packed {
        logic             pcEn;
        logic             ifidEn;
        logic             ifidFlush;
        logic             idexEn;
        logic             idexBubble;
        logic             exmemBubble;
        logic             mulBusy;
        logic [CNT_W-1:0] stallCnt;
    } resp_t;

    logic  clk;
    logic  rst;
    resp_t expQ[$];
    string tagQ[$];
    int    checkCount;
    int    passCount;
    int    freezeLeft;
    int    modelStall;

    pipeline_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.RA_W(RA_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        s.opcode = 4'b0001;
        return s;
    endfunction

    // Drive one cycle of inputs and push what the pipeline should do this cycle.
    task automatic applyStimulus(input stim_t s, input string tag);
        resp_t e;
        logic  lu;
        @(posedge clk);
        #1;
        rst                   = s.reset;
        bus.i_id_valid        = s.valid;
        bus.i_id_opcode       = s.opcode;
        bus.i_id_rs           = s.rs;
        bus.i_id_rt           = s.rt;
        bus.i_id_uses_rt      = s.usesRt;
        bus.i_ex_memtoreg     = s.memToReg;
        bus.i_ex_rd           = s.rd;
        bus.i_ex_branch_taken = s.branch;
        bus.i_ext_hold        = s.hold;

        lu = s.valid && s.memToReg && ((s.rd == s.rs) || (s.usesRt && s.rd == s.rt));
        e = '0;
        e.pcEn     = 1'b1;
        e.ifidEn   = 1'b1;
        e.idexEn   = 1'b1;
        e.mulBusy  = (freezeLeft > 0);
        e.stallCnt = CNT_W'(modelStall);
        if (s.hold) begin
            e.pcEn   = 1'b0;
            e.ifidEn = 1'b0;
            e.idexEn = 1'b0;
        end else if (freezeLeft > 0) begin
            e.pcEn        = 1'b0;
            e.ifidEn      = 1'b0;
            e.idexEn      = 1'b0;
            e.exmemBubble = 1'b1;
            freezeLeft--;
        end else if (s.branch) begin
            e.ifidFlush  = 1'b1;
            e.idexBubble = 1'b1;
        end else if (lu) begin
            e.pcEn       = 1'b0;
            e.ifidEn     = 1'b0;
            e.idexBubble = 1'b1;
        end else if (s.valid && (s.opcode == 4'b0100 || s.opcode == 4'b1000)) begin
            freezeLeft = MUL_LAT - 1;
        end

        if (s.reset) begin
            freezeLeft = 0;
            modelStall = 0;
        end else if (!e.pcEn && modelStall < CNT_MAX) begin
            modelStall++;
        end
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        resp_t e;
        resp_t g;
        string tag;
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        g.pcEn        = bus.o_pc_en;
        g.ifidEn      = bus.o_ifid_en;
        g.ifidFlush   = bus.o_ifid_flush;
        g.idexEn      = bus.o_idex_en;
        g.idexBubble  = bus.o_idex_bubble;
        g.exmemBubble = bus.o_exmem_bubble;
        g.mulBusy     = bus.o_mul_busy;
        g.stallCnt    = bus.o_stall_cnt;
        checkCount++;
        if (g === e) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got ctrl=%b stall=%0d, expected ctrl=%b stall=%0d",
                     tag, g[CNT_W+6:CNT_W], g.stallCnt, e[CNT_W+6:CNT_W], e.stallCnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput();
        end
    end

    task automatic mulIssue();
        stim_t s;
        s = idleStim();
        s.valid  = 1'b1;
        s.opcode = 4'b1000;
        applyStimulus(s, "mul_issue");
    endtask

    initial begin
        stim_t s;
        int    waitCycles;
        checkCount = 0;
        passCount  = 0;
        freezeLeft = 0;
        modelStall = 0;
        s = idleStim();
        rst                   = 1'b1;
        bus.i_id_valid        = 1'b0;
        bus.i_id_opcode       = 4'b0001;
        bus.i_id_rs           = '0;
        bus.i_id_rt           = '0;
        bus.i_id_uses_rt      = 1'b0;
        bus.i_ex_memtoreg     = 1'b0;
        bus.i_ex_rd           = '0;
        bus.i_ex_branch_taken = 1'b0;
        bus.i_ext_hold        = 1'b0;
        repeat (2) @(posedge clk);

        s.reset = 1'b1;
        applyStimulus(s, "reset");
        applyStimulus(s, "reset");
        s = idleStim();
        applyStimulus(s, "after_reset");

        s = idleStim();
        s.valid = 1'b1; s.memToReg = 1'b1; s.rd = 4'd3; s.rs = 4'd3; s.rt = 4'd5; s.usesRt = 1'b1;
        applyStimulus(s, "loaduse_rs");
        s.memToReg = 1'b0;
        applyStimulus(s, "loaduse_release");
        s = idleStim();
        s.valid = 1'b1; s.memToReg = 1'b1; s.rd = 4'd3; s.rs = 4'd1; s.rt = 4'd3; s.usesRt = 1'b0;
        applyStimulus(s, "loaduse_imm_rt");
        s.usesRt = 1'b1;
        applyStimulus(s, "loaduse_rt");
        s = idleStim();
        s.valid = 1'b1; s.memToReg = 1'b1; s.rd = 4'd0; s.rs = 4'd0;
        applyStimulus(s, "loaduse_r0");

        mulIssue();
        s = idleStim();
        applyStimulus(s, "mul_wait");
        applyStimulus(s, "mul_wait");
        applyStimulus(s, "mul_done");

        s = idleStim();
        s.valid = 1'b1; s.memToReg = 1'b1; s.rd = 4'd7; s.rs = 4'd7; s.branch = 1'b1;
        applyStimulus(s, "branch_loaduse");

        mulIssue();
        applyStimulus(s, "mul_wait_ignore_branch");
        s = idleStim();
        applyStimulus(s, "mul_wait");
        mulIssue();
        applyStimulus(s, "mul_b2b_wait");

        s = idleStim();
        s.hold = 1'b1;
        repeat (4) applyStimulus(s, "hold_in_mul_wait");
        s = idleStim();
        applyStimulus(s, "mul_resume");
        applyStimulus(s, "mul_done");

        mulIssue();
        s = idleStim();
        applyStimulus(s, "mul_wait");
        s.reset = 1'b1;
        applyStimulus(s, "reset_in_mul_wait");
        s = idleStim();
        applyStimulus(s, "after_mul_reset");

        s = idleStim();
        s.hold = 1'b1;
        repeat (CNT_MAX + 8) applyStimulus(s, "saturate");
        s = idleStim();
        s.reset = 1'b1;
        applyStimulus(s, "reset_after_sat");

        for (int i = 0; i < 600; i++) begin
            s = idleStim();
            s.reset    = ($urandom_range(0, 99) < 2);
            s.valid    = ($urandom_range(0, 9) != 0);
            s.opcode   = 4'($urandom_range(0, 15));
            s.rs       = RA_W'($urandom_range(0, 3));
            s.rt       = RA_W'($urandom_range(0, 3));
            s.usesRt   = 1'($urandom_range(0, 1));
            s.memToReg = ($urandom_range(0, 9) < 3);
            s.rd       = RA_W'($urandom_range(0, 3));
            s.branch   = ($urandom_range(0, 99) < 15);
            s.hold     = ($urandom_range(0, 9) == 0);
            applyStimulus(s, "random");
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: got %0d pending responses, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
